// File: rtl/gate_tt_pkg.sv
// Shared definitions for the gate truth-table checker: FSM encoding and
// expected tables indexed by stim value (stim[N-1] is operand a).
package gate_tt_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [1:0] TT_NOT  = 2'b01;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer: counts cycles while enabled and pulses tick on the
// SETTLE-th cycle, then starts over for the next combination.
module tt_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == CNT_W'(SETTLE - 1));

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table runner: walks every input combination of a gate under test,
// samples its output after the settle time and compares against EXPECT.
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int                N      = 2,
    parameter int                SETTLE = 1,
    parameter logic [(1<<N)-1:0] EXPECT = TT_AND
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [N-1:0]        stim,
    input  logic                dut_out,
    output logic                busy,
    output logic                row_valid,
    output logic [N-1:0]        row_idx,
    output logic                row_out,
    output logic [(1<<N)-1:0]   observed,
    output logic [(1<<N)-1:0]   mismatch,
    output logic                done,
    output logic                pass
);

    localparam logic [N-1:0] LAST = '1;

    logic [1:0] state;
    logic       restart;
    logic       tick;

    // A start is only honoured outside a run; the same condition rearms the timer.
    assign restart = start && (state != ST_SETTLE);

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .enable  (state == ST_SETTLE),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            stim      <= '0;
            busy      <= 1'b0;
            row_valid <= 1'b0;
            row_idx   <= '0;
            row_out   <= 1'b0;
            observed  <= '0;
            done      <= 1'b0;
        end else begin
            row_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_SETTLE;
                        stim     <= '0;
                        observed <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (tick) begin
                        observed[stim] <= dut_out;
                        row_valid      <= 1'b1;
                        row_idx        <= stim;
                        row_out        <= dut_out;
                        // Last-row test precedes the increment, so stim never wraps.
                        if (stim == LAST) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            stim <= stim + N'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mismatch = done ? (observed ^ EXPECT) : '0;
    assign pass     = done && (mismatch == '0);

endmodule

// File: tb/tb_gate_tt_checker.sv
// Self-checking bench: three checker instances driven by gates modelled as
// truth tables; a cycle-accurate reference of the run is computed per cycle.
module tb_gate_tt_checker;
    import gate_tt_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    int         sel;
    logic [7:0] gate_table;
    int         tests = 0;
    int         fails = 0;

    logic       start_a, start_b, start_c;
    logic [1:0] stim_a, stim_b, row_idx_a, row_idx_b;
    logic [0:0] stim_c, row_idx_c;
    logic [3:0] obs_a, obs_b, mis_a, mis_b;
    logic [1:0] obs_c, mis_c;
    logic       busy_a, busy_b, busy_c, rv_a, rv_b, rv_c;
    logic       ro_a, ro_b, ro_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    gate_tt_checker #(.N(2), .SETTLE(1), .EXPECT(TT_AND)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stim(stim_a),
        .dut_out(gate_table[stim_a]), .busy(busy_a), .row_valid(rv_a),
        .row_idx(row_idx_a), .row_out(ro_a), .observed(obs_a),
        .mismatch(mis_a), .done(done_a), .pass(pass_a)
    );

    gate_tt_checker #(.N(2), .SETTLE(3), .EXPECT(TT_XOR)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stim(stim_b),
        .dut_out(gate_table[stim_b]), .busy(busy_b), .row_valid(rv_b),
        .row_idx(row_idx_b), .row_out(ro_b), .observed(obs_b),
        .mismatch(mis_b), .done(done_b), .pass(pass_b)
    );

    gate_tt_checker #(.N(1), .SETTLE(2), .EXPECT(TT_NOT)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_c), .stim(stim_c),
        .dut_out(gate_table[stim_c]), .busy(busy_c), .row_valid(rv_c),
        .row_idx(row_idx_c), .row_out(ro_c), .observed(obs_c),
        .mismatch(mis_c), .done(done_c), .pass(pass_c)
    );

    logic [7:0] p_stim, p_row_idx, p_observed, p_mismatch;
    logic       p_busy, p_row_valid, p_row_out, p_done, p_pass;

    always_comb begin
        p_stim = '0; p_row_idx = '0; p_observed = '0; p_mismatch = '0;
        p_busy = 1'b0; p_row_valid = 1'b0; p_row_out = 1'b0; p_done = 1'b0; p_pass = 1'b0;
        case (sel)
            0: begin
                p_stim = 8'(stim_a); p_row_idx = 8'(row_idx_a); p_observed = 8'(obs_a);
                p_mismatch = 8'(mis_a); p_busy = busy_a; p_row_valid = rv_a;
                p_row_out = ro_a; p_done = done_a; p_pass = pass_a;
            end
            1: begin
                p_stim = 8'(stim_b); p_row_idx = 8'(row_idx_b); p_observed = 8'(obs_b);
                p_mismatch = 8'(mis_b); p_busy = busy_b; p_row_valid = rv_b;
                p_row_out = ro_b; p_done = done_b; p_pass = pass_b;
            end
            default: begin
                p_stim = 8'(stim_c); p_row_idx = 8'(row_idx_c); p_observed = 8'(obs_c);
                p_mismatch = 8'(mis_c); p_busy = busy_c; p_row_valid = rv_c;
                p_row_out = ro_c; p_done = done_c; p_pass = pass_c;
            end
        endcase
    end

    // Truth table of a named gate: op 0 and, 1 or, 2 xor, 3 nand, 4 not(a).
    function automatic logic [7:0] gate_tt(input int op, input int n);
        logic [7:0] t;
        int a, b, y;
        t = '0;
        for (int k = 0; k < (1 << n); k++) begin
            a = (k >> (n - 1)) & 1;
            b = k & 1;
            case (op)
                0:       y = a & b;
                1:       y = a | b;
                2:       y = a ^ b;
                3:       y = 1 - (a & b);
                default: y = 1 - a;
            endcase
            t[k] = y[0];
        end
        return t;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stim"}, p_stim, 8'd0);
        check({tag, "_busy"}, 8'(p_busy), 8'd0);
        check({tag, "_row_valid"}, 8'(p_row_valid), 8'd0);
        check({tag, "_row_idx"}, p_row_idx, 8'd0);
        check({tag, "_row_out"}, 8'(p_row_out), 8'd0);
        check({tag, "_observed"}, p_observed, 8'd0);
        check({tag, "_mismatch"}, p_mismatch, 8'd0);
        check({tag, "_done"}, 8'(p_done), 8'd0);
        check({tag, "_pass"}, 8'(p_pass), 8'd0);
    endtask

    // Runs one complete table on instance sel_i; called at a falling edge.
    task automatic run_check(input int sel_i, input int n, input int settle,
                             input logic [7:0] tt, input logic [7:0] exp_tt,
                             input bit spam, input int hold);
        int         rows, len, captured, pulses;
        logic [7:0] mask, tt_m, cap_mask;
        rows   = 1 << n;
        len    = rows * settle;
        mask   = 8'((1 << rows) - 1);
        tt_m   = tt & mask;
        sel    = sel_i;
        gate_table = tt_m;
        pulses = 0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        for (int c = 1; c <= len; c++) begin
            if (spam) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            captured = c / settle;
            cap_mask = 8'((1 << captured) - 1);
            check("busy", 8'(p_busy), 8'(c < len));
            check("done", 8'(p_done), 8'(c == len));
            check("stim", p_stim, 8'((captured < rows) ? captured : rows - 1));
            check("row_valid", 8'(p_row_valid), 8'((c % settle) == 0));
            if ((c % settle) == 0) begin
                pulses++;
                check("row_idx", p_row_idx, 8'(captured - 1));
                check("row_out", 8'(p_row_out), 8'(tt_m[captured - 1]));
            end
            check("observed", p_observed, tt_m & cap_mask);
        end
        start = 1'b0;
        check("row_pulses", 8'(pulses), 8'(rows));
        check("mismatch", p_mismatch, (tt_m ^ exp_tt) & mask);
        check("pass", 8'(p_pass), 8'(tt_m == (exp_tt & mask)));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_done", 8'(p_done), 8'd1);
            check("hold_row_valid", 8'(p_row_valid), 8'd0);
            check("hold_stim", p_stim, 8'(rows - 1));
            check("hold_observed", p_observed, tt_m);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sel   = 0;
        gate_table = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run_check(0, 2, 1, gate_tt(0, 2), 8'(TT_AND), 1'b0, 0);
        run_check(0, 2, 1, gate_tt($urandom_range(0, 3), 2), 8'(TT_AND), 1'b0, 2);

        run_check(1, 2, 3, gate_tt(2, 2), 8'(TT_XOR), 1'b0, 1);
        run_check(1, 2, 3, gate_tt(0, 2), 8'(TT_XOR), 1'b0, 1);
        for (int i = 0; i < 3; i++)
            run_check(1, 2, 3, 8'($urandom), 8'(TT_XOR), 1'b0, 1);

        run_check(0, 2, 1, gate_tt(1, 2), 8'(TT_AND), 1'b1, 1);

        sel = 0;
        gate_table = gate_tt(0, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset_idle");
        run_check(0, 2, 1, gate_tt(0, 2), 8'(TT_AND), 1'b0, 1);

        run_check(2, 1, 2, gate_tt(4, 1), 8'(TT_NOT), 1'b0, 1);
        run_check(2, 1, 2, 8'($urandom), 8'(TT_NOT), 1'b0, 1);

        for (int i = 0; i < 3; i++)
            run_check(0, 2, 1, gate_tt($urandom_range(0, 3), 2), 8'(TT_AND), 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
